// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Optional MDU_EARLY_EXIT_EN: multiplies leave CALC as soon as the remaining multiplier is zero.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             DIV_ZERO
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

  state_t             state, state_next;
  logic [1:0]         op_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               neg_res;
  logic               neg_rem;

  logic               is_div;
  logic               is_signed;
  logic               div_by_zero;
  logic               calc_last;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic               fits;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    is_div      = op_reg[1];
    is_signed   = ~op_reg[0];
    div_by_zero = is_div && (b_reg == '0);
    a_abs       = (is_signed && a_reg[WIDTH-1]) ? -a_reg : a_reg;
    b_abs       = (is_signed && b_reg[WIDTH-1]) ? -b_reg : b_reg;
    // acc holds {remainder, dividend/quotient} during division
    trial       = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff        = trial - {1'b0, b_reg};
    fits        = ~diff[WIDTH];
    prod_fix    = neg_res ? -acc : acc;
    quo_fix     = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix     = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
`ifdef MDU_EARLY_EXIT_EN
    calc_last   = (cnt == CW'(1)) || (!is_div && (b_reg[WIDTH-1:1] == '0));
`else
    calc_last   = (cnt == CW'(1));
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    BUSY       = 1'b0;
    DONE       = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        DONE       = (state == S_DONE);
        state_next = START ? S_PREP : S_IDLE;
      end
      S_PREP: begin
        BUSY       = 1'b1;
        state_next = div_by_zero ? S_DONE : S_CALC;
      end
      S_CALC: begin
        BUSY = 1'b1;
        if (calc_last) state_next = S_FIX;
      end
      S_FIX: begin
        BUSY       = 1'b1;
        state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      op_reg   <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      mcand    <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      HI       <= '0;
      LO       <= '0;
      DIV_ZERO <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (START) begin
            op_reg   <= OP;
            a_reg    <= A;
            b_reg    <= B;
            DIV_ZERO <= 1'b0;
          end
        end
        S_PREP: begin
          cnt     <= CW'(WIDTH);
          neg_res <= is_signed & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
          neg_rem <= is_signed & a_reg[WIDTH-1];
          b_reg   <= b_abs;
          if (is_div) begin
            acc   <= {{WIDTH{1'b0}}, a_abs};
            mcand <= '0;
          end else begin
            acc   <= '0;
            mcand <= {{WIDTH{1'b0}}, a_abs};
          end
          // zero divisor bypasses CALC/FIX and reports the raw dividend
          if (div_by_zero) begin
            HI       <= a_reg;
            LO       <= '1;
            DIV_ZERO <= 1'b1;
          end
        end
        S_CALC: begin
          cnt <= cnt - CW'(1);
          if (is_div) begin
            if (fits) acc <= {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else      acc <= {acc[2*WIDTH-2:0], 1'b0};
          end else begin
            if (b_reg[0]) acc <= acc + mcand;
            mcand <= {mcand[2*WIDTH-2:0], 1'b0};
            b_reg <= {1'b0, b_reg[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          if (is_div) begin
            HI <= rem_fix;
            LO <= quo_fix;
          end else begin
            HI <= prod_fix[2*WIDTH-1:WIDTH];
            LO <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
